// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg
// MEM->WB pipeline register with a valid/ready handshake and a two-entry
// skid buffer (main + skid). The upstream ready comes straight from the skid
// valid flop, so out_ready has no combinational path to in_ready.
//
// Optional feature macro: MEM_WB_WBMUX_EN
//   When defined, adds output WB_value = MEM_R_en ? Mem_read_value : ALU_result.
//   The select happens at capture time and is stored with the entry.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every held entry at the next edge
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   *_in                incoming entry fields
//   out_valid/out_ready downstream handshake
//   WB_en               stored write-back enable gated by out_valid
//   MEM_R_en, ALU_result, Mem_read_value, Dest   stored output entry
//   WB_value            (MEM_WB_WBMUX_EN only) pre-selected write-back data
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_en_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic [DEST_W-1:0] Dest
`ifdef MEM_WB_WBMUX_EN
  ,
  output logic [DATA_W-1:0] WB_value
`endif
);

  // Entry payload: {WB_en, MEM_R_en, ALU_result, Mem_read_value, Dest[, WB_value]}
`ifdef MEM_WB_WBMUX_EN
  localparam int PW = 2 + 3 * DATA_W + DEST_W;
`else
  localparam int PW = 2 + 2 * DATA_W + DEST_W;
`endif

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_reg, main_next;
  logic [PW-1:0] skid_reg, skid_next;
  logic          main_valid_reg, main_valid_next;
  logic          skid_valid_reg, skid_valid_next;
  logic          accept;
  logic          drain;
  logic          wb_en_st;

`ifdef MEM_WB_WBMUX_EN
  assign in_pl = {WB_en_in, MEM_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in,
                  (MEM_R_en_in ? Mem_read_value_in : ALU_result_in)};
  assign {wb_en_st, MEM_R_en, ALU_result, Mem_read_value, Dest, WB_value} = main_reg;
`else
  assign in_pl = {WB_en_in, MEM_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};
  assign {wb_en_st, MEM_R_en, ALU_result, Mem_read_value, Dest} = main_reg;
`endif

  assign in_ready  = ~skid_valid_reg;
  assign out_valid = main_valid_reg;
  // A bubble must never write the register file.
  assign WB_en     = wb_en_st & main_valid_reg;

  assign accept = in_valid & ~skid_valid_reg;
  assign drain  = main_valid_reg & out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_next       = main_reg;
    skid_next       = skid_reg;
    if (flush) begin
      // Data fields are left as-is; only the valid bits matter.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      case ({main_valid_reg, skid_valid_reg})
        2'b00: begin
          if (accept) begin
            main_next       = in_pl;
            main_valid_next = 1'b1;
          end
        end
        2'b10: begin
          if (accept && drain) begin
            main_next = in_pl;
          end else if (accept) begin
            // Downstream stalled: park the new entry in the skid slot.
            skid_next       = in_pl;
            skid_valid_next = 1'b1;
          end else if (drain) begin
            main_valid_next = 1'b0;
          end
        end
        2'b11: begin
          // in_ready is low here, so no accept can coincide with the drain.
          if (drain) begin
            main_next       = skid_reg;
            skid_valid_next = 1'b0;
          end
        end
        default: begin
          // Skid-only is unreachable; recover to EMPTY.
          main_valid_next = 1'b0;
          skid_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_reg       <= main_next;
      skid_reg       <= skid_next;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Testbench for mem_wb_skid_reg. The reference model is an in-order queue of
// accepted entries with capacity two: an entry is accepted when fewer than two
// are held, the head is the output entry, a drain pops the head, and flush or
// reset empties the queue. A monitor on the falling edge compares the DUT
// outputs against the queue head.
module tb_mem_wb_skid_reg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              WB_en_in = 1'b0;
  logic              MEM_R_en_in = 1'b0;
  logic [DATA_W-1:0] ALU_result_in = '0;
  logic [DATA_W-1:0] Mem_read_value_in = '0;
  logic [DEST_W-1:0] Dest_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              WB_en;
  logic              MEM_R_en;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] Mem_read_value;
  logic [DEST_W-1:0] Dest;
`ifdef MEM_WB_WBMUX_EN
  logic [DATA_W-1:0] WB_value;
`endif

  mem_wb_skid_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in),
    .ALU_result_in(ALU_result_in), .Mem_read_value_in(Mem_read_value_in),
    .Dest_in(Dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_en(WB_en), .MEM_R_en(MEM_R_en), .ALU_result(ALU_result),
    .Mem_read_value(Mem_read_value), .Dest(Dest)
`ifdef MEM_WB_WBMUX_EN
    , .WB_value(WB_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              wbe;
    logic              mre;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mrv;
    logic [DEST_W-1:0] dst;
  } ent_t;

  ent_t q[$];
  int   held_cnt = 0;       // entries held by the DUT after the last edge
  bit   clear_pending = 0;  // last edge applied flush or reset
  bit   mon_en = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge; record the
  // expected accept for the following edge in the scoreboard.
  task automatic step(input logic iv, input logic wbe, input logic mre,
                      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mrv,
                      input logic [DEST_W-1:0] dst, input logic ordy,
                      input logic fl, input logic r);
    ent_t e;
    @(posedge clk);
    #1;
    if (clear_pending) q.delete();
    held_cnt          = q.size();
    in_valid          = iv;
    WB_en_in          = wbe;
    MEM_R_en_in       = mre;
    ALU_result_in     = alu;
    Mem_read_value_in = mrv;
    Dest_in           = dst;
    out_ready         = ordy;
    flush             = fl;
    rst               = r;
    clear_pending     = fl | r;
    mon_en            = 1;
    if (iv && held_cnt < 2 && !fl && !r) begin
      e.wbe = wbe; e.mre = mre; e.alu = alu; e.mrv = mrv; e.dst = dst;
      q.push_back(e);
    end
  endtask

  // Monitor: compare against the model head; pop when the DUT will drain.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(held_cnt < 2));
      chk("out_valid", 32'(out_valid), 32'(held_cnt > 0));
      if (held_cnt > 0 && q.size() > 0) begin
        chk("WB_en", 32'(WB_en), 32'(q[0].wbe));
        chk("MEM_R_en", 32'(MEM_R_en), 32'(q[0].mre));
        chk("ALU_result", ALU_result, q[0].alu);
        chk("Mem_read_value", Mem_read_value, q[0].mrv);
        chk("Dest", 32'(Dest), 32'(q[0].dst));
`ifdef MEM_WB_WBMUX_EN
        chk("WB_value", WB_value, q[0].mre ? q[0].mrv : q[0].alu);
`endif
        if (out_ready && !flush && !rst) begin
          $display("drain: dest=%0d alu=0x%0h mrv=0x%0h wbe=%0b mre=%0b",
                   Dest, ALU_result, Mem_read_value, WB_en, MEM_R_en);
          void'(q.pop_front());
        end
      end else begin
        chk("WB_en_bubble", 32'(WB_en), 32'd0);
      end
    end
  end

  initial begin
    // Reset for two edges while offering an entry: it must be lost.
    step(1, 1, 0, 32'h55, 32'h66, 4'd7, 1, 0, 1);
    step(1, 1, 0, 32'h55, 32'h66, 4'd7, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_WB_en", 32'(WB_en), 32'd0);
    chk("rst_MEM_R_en", 32'(MEM_R_en), 32'd0);
    chk("rst_ALU_result", ALU_result, 32'd0);
    chk("rst_Mem_read_value", Mem_read_value, 32'd0);
    chk("rst_Dest", 32'(Dest), 32'd0);
`ifdef MEM_WB_WBMUX_EN
    chk("rst_WB_value", WB_value, 32'd0);
`endif

    // Back-to-back stream with out_ready high.
    for (int i = 1; i <= 4; i++)
      step(1, 1, 0, 32'(i), 32'(i + 100), 4'(i), 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Backpressure: offer 1, 2, 3 with out_ready low; 3 stays upstream.
    for (int i = 1; i <= 3; i++)
      step(1, 1, 1, 32'(i + 16), 32'(i + 32), 4'(i), 0, 0, 0);
    step(1, 1, 1, 32'h13, 32'h23, 4'd3, 0, 0, 0);
    // Release: keep offering entry 3 until taken, then drain.
    step(1, 1, 1, 32'h13, 32'h23, 4'd3, 1, 0, 0);
    step(1, 1, 1, 32'h13, 32'h23, 4'd3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Flush while FULL with an entry offered.
    step(1, 1, 0, 32'hA1, 0, 4'd1, 0, 0, 0);
    step(1, 1, 0, 32'hA2, 0, 4'd2, 0, 0, 0);
    step(1, 1, 0, 32'hA3, 0, 4'd3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Flush while ONE with a simultaneous accept: the accept is discarded.
    step(1, 1, 0, 32'hB1, 0, 4'd4, 0, 0, 0);
    step(1, 1, 0, 32'hB2, 0, 4'd5, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Bubble gating: one write-back entry, then nothing.
    step(1, 1, 0, 32'hC0, 0, 4'd9, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0);

    // Write-back select cases (also covered by the field checks by default).
    step(1, 1, 1, 32'h10, 32'hDEAD, 4'd2, 1, 0, 0);
    step(1, 1, 0, 32'h10, 32'hDEAD, 4'd3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Randomised traffic with stalls, flushes and the odd reset.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 199) == 0);

    // Drain everything and confirm nothing was lost or left behind.
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
